// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame constants.
package uart_pkg;

   localparam int unsigned DATA_BITS            = 8;
   localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } rx_state_e;

endpackage

// File: rtl/rx_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted when a pop occurs in the same cycle.
module rx_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   fill_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      fill_q;
   logic             do_pop_c;
   logic             do_push_c;

   assign empty_o   = (fill_q == '0);
   assign full_o    = (fill_q == (AW+1)'(DEPTH));
   assign fill_o    = fill_q;
   assign rdata_o   = mem_q[rd_ptr_q];
   assign do_pop_c  = pop_i && !empty_o;
   assign do_push_c = push_i && (!full_o || do_pop_c);

   // Storage, pointers (power-of-two depth wraps naturally) and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (do_push_c) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (do_pop_c) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         if (do_push_c && !do_pop_c) begin
            fill_q <= fill_q + (AW+1)'(1);
         end else if (do_pop_c && !do_push_c) begin
            fill_q <= fill_q - (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, frame-error detection and a small receive FIFO.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rxd,
   output logic [DATA_BITS-1:0]          rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic                          frame_err,
   output logic                          overrun,
   output logic [$clog2(FIFO_DEPTH):0]   fill
);

   localparam int unsigned TW = $clog2(CLKS_PER_BIT);
   localparam int unsigned IW = $clog2(DATA_BITS);

   rx_state_e            state_q, state_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 sync1_q, rxd_s_q;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q, overrun_d;
   logic                 push_c;
   logic                 pop_c;
   logic                 full_c;
   logic                 empty_c;

   assign rx_valid  = !empty_c;
   assign pop_c     = rx_valid && rx_ready;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

   // Two-flop synchronizer on the asynchronous serial line; idles high.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b1;
         rxd_s_q <= 1'b1;
      end else begin
         sync1_q <= rxd;
         rxd_s_q <= sync1_q;
      end
   end

   // Receiver state and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         timer_q     <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   // Frame decoding: centre the start bit, then sample each data bit and the stop bit one bit time apart.
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q + TW'(1);
      idx_d       = idx_q;
      shift_d     = shift_q;
      frame_err_d = 1'b0;
      push_c      = 1'b0;
      unique case (state_q)
         IDLE: begin
            timer_d = '0;
            if (!rxd_s_q) state_d = START;
         end
         START: begin
            if (timer_q == TW'(CLKS_PER_BIT / 2 - 1)) begin
               timer_d = '0;
               idx_d   = '0;
               state_d = rxd_s_q ? IDLE : DATA;
            end
         end
         DATA: begin
            if (timer_q == TW'(CLKS_PER_BIT - 1)) begin
               timer_d        = '0;
               shift_d[idx_q] = rxd_s_q;
               if (idx_q == IW'(DATA_BITS - 1)) begin
                  state_d = STOP;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         STOP: begin
            if (timer_q == TW'(CLKS_PER_BIT - 1)) begin
               timer_d = '0;
               if (rxd_s_q) begin
                  push_c  = 1'b1;
                  state_d = IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = WAIT_IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            timer_d = '0;
            if (rxd_s_q) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Sticky overrun: a completed byte found the FIFO full with no pop to make room.
   always_comb begin
      overrun_d = overrun_q | (push_c && full_c && !pop_c);
   end

   rx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push_c),
      .wdata_i (shift_q),
      .pop_i   (pop_c),
      .rdata_o (rx_data),
      .full_o  (full_c),
      .empty_o (empty_c),
      .fill_o  (fill)
   );

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 8 clocks per bit and a 4-entry FIFO.
module tb_uart_rx;

   localparam int unsigned CPB   = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned FW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          rxd;
   logic          rx_ready;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          frame_err;
   logic          overrun;
   logic [FW-1:0] fill;

   logic [7:0] expq [$];
   logic [7:0] exp_b;
   int n_tests      = 0;
   int n_fail       = 0;
   int fe_cycles    = 0;
   int valid_cycles = 0;
   int n_rx         = 0;

   uart_rx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rxd       (rxd),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .fill      (fill)
   );

   always #5 clk = ~clk;

   // Monitor: count pulses and compare every popped byte against the scoreboard head.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (frame_err === 1'b1) fe_cycles++;
         if (rx_valid === 1'b1) valid_cycles++;
         if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
            n_tests++;
            if (expq.size() == 0) begin
               n_fail++;
               $display("FAIL pop_unexpected: got %h, required no byte", rx_data);
            end else begin
               exp_b = expq.pop_front();
               n_rx++;
               if (rx_data !== exp_b) begin
                  n_fail++;
                  $display("FAIL pop_data: got %h, required %h", rx_data, exp_b);
               end
            end
         end
      end
   end

   // Advance n clocks; inputs change 1 ns after the rising edge.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit);
      rxd = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rxd = d[i];
         tick(CPB);
      end
      rxd = stop_bit;
      tick(CPB);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      rxd = 1'b1;
      expq.delete();
      tick(3);
      rst = 1'b0;
      tick(2);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rxd = 1'b1;
      rx_ready = 1'b0;
      tick(3);
      n_tests++;
      if (rx_valid !== 1'b0 || fill !== FW'(0) || rx_data !== 8'h00 ||
          frame_err !== 1'b0 || overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got valid=%b fill=%0d data=%h fe=%b ovr=%b, required 0 0 00 0 0",
                  rx_valid, fill, rx_data, frame_err, overrun);
      end
      rst = 1'b0;
      tick(2);
   endtask

   task automatic test_single();
      int v0, fe0, r0;
      v0 = valid_cycles; fe0 = fe_cycles; r0 = n_rx;
      rx_ready = 1'b1;
      expq.push_back(8'hA5);
      send_frame(8'hA5, 1'b1);
      tick(4);
      n_tests++;
      if (valid_cycles - v0 != 1) begin
         n_fail++;
         $display("FAIL single_valid_cycles: got %0d, required 1", valid_cycles - v0);
      end
      n_tests++;
      if (fe_cycles != fe0 || n_rx - r0 != 1) begin
         n_fail++;
         $display("FAIL single_rx: got fe=%0d rx=%0d, required fe=0 rx=1", fe_cycles - fe0, n_rx - r0);
      end
   endtask

   task automatic test_glitch();
      int v0, fe0;
      v0 = valid_cycles; fe0 = fe_cycles;
      rxd = 1'b0;
      tick(3);
      rxd = 1'b1;
      tick(30);
      n_tests++;
      if (valid_cycles != v0 || fe_cycles != fe0 || fill !== FW'(0)) begin
         n_fail++;
         $display("FAIL glitch_reject: got valid=%0d fe=%0d fill=%0d, required 0 0 0",
                  valid_cycles - v0, fe_cycles - fe0, fill);
      end
   endtask

   task automatic test_frame_err();
      int v0, fe0, r0;
      v0 = valid_cycles; fe0 = fe_cycles;
      rx_ready = 1'b1;
      send_frame(8'h3C, 1'b0);
      tick(40);
      rxd = 1'b1;
      tick(16);
      n_tests++;
      if (fe_cycles - fe0 != 1) begin
         n_fail++;
         $display("FAIL frame_err_pulses: got %0d cycles, required 1", fe_cycles - fe0);
      end
      n_tests++;
      if (fill !== FW'(0) || valid_cycles != v0) begin
         n_fail++;
         $display("FAIL frame_err_discard: got fill=%0d valid=%0d, required 0 0", fill, valid_cycles - v0);
      end
      r0 = n_rx;
      expq.push_back(8'h55);
      send_frame(8'h55, 1'b1);
      tick(4);
      n_tests++;
      if (n_rx - r0 != 1 || fe_cycles - fe0 != 1) begin
         n_fail++;
         $display("FAIL frame_err_recover: got rx=%0d fe=%0d, required 1 1", n_rx - r0, fe_cycles - fe0);
      end
   endtask

   task automatic test_back_to_back();
      int v0, r0;
      logic [7:0] b;
      v0 = valid_cycles; r0 = n_rx;
      rx_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         b = 8'($urandom_range(0, 255));
         expq.push_back(b);
         send_frame(b, 1'b1);
      end
      tick(4);
      n_tests++;
      if (n_rx - r0 != 4 || valid_cycles - v0 != 4) begin
         n_fail++;
         $display("FAIL back_to_back: got rx=%0d valid=%0d, required 4 4", n_rx - r0, valid_cycles - v0);
      end
   endtask

   task automatic test_overrun();
      int r0;
      rx_ready = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         if (k <= 4) expq.push_back(8'(k));
         send_frame(8'(k), 1'b1);
         tick(2);
         if (k == 4) begin
            n_tests++;
            if (fill !== FW'(4) || overrun !== 1'b0) begin
               n_fail++;
               $display("FAIL overrun_pre: got fill=%0d ovr=%b, required 4 0", fill, overrun);
            end
         end
      end
      tick(4);
      n_tests++;
      if (fill !== FW'(4) || overrun !== 1'b1 || rx_data !== 8'h01) begin
         n_fail++;
         $display("FAIL overrun_set: got fill=%0d ovr=%b head=%h, required 4 1 01", fill, overrun, rx_data);
      end
      r0 = n_rx;
      rx_ready = 1'b1;
      tick(8);
      n_tests++;
      if (n_rx - r0 != 4 || fill !== FW'(0) || overrun !== 1'b1) begin
         n_fail++;
         $display("FAIL overrun_drain: got rx=%0d fill=%0d ovr=%b, required 4 0 1", n_rx - r0, fill, overrun);
      end
   endtask

   task automatic test_reset_mid_frame();
      int fe0, r0;
      rx_ready = 1'b0;
      expq.push_back(8'h42);
      send_frame(8'h42, 1'b1);
      tick(2);
      n_tests++;
      if (fill !== FW'(1) || rx_data !== 8'h42 || overrun !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset_state: got fill=%0d data=%h ovr=%b, required 1 42 1", fill, rx_data, overrun);
      end
      rxd = 1'b0;
      tick(CPB);
      for (int i = 0; i < 4; i++) begin
         rxd = 1'b1;
         tick(CPB);
      end
      rxd = 1'b1;
      tick(4);
      rst = 1'b1;
      expq.delete();
      tick(2);
      n_tests++;
      if (rx_valid !== 1'b0 || fill !== FW'(0) || rx_data !== 8'h00 ||
          frame_err !== 1'b0 || overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_outputs: got valid=%b fill=%0d data=%h fe=%b ovr=%b, required 0 0 00 0 0",
                  rx_valid, fill, rx_data, frame_err, overrun);
      end
      rst = 1'b0;
      fe0 = fe_cycles;
      tick(80);
      n_tests++;
      if (fill !== FW'(0) || fe_cycles != fe0) begin
         n_fail++;
         $display("FAIL mid_reset_no_push: got fill=%0d fe=%0d, required 0 0", fill, fe_cycles - fe0);
      end
      r0 = n_rx;
      rx_ready = 1'b1;
      expq.push_back(8'h81);
      send_frame(8'h81, 1'b1);
      tick(4);
      n_tests++;
      if (n_rx - r0 != 1) begin
         n_fail++;
         $display("FAIL mid_reset_next_frame: got rx=%0d, required 1", n_rx - r0);
      end
   endtask

   task automatic test_full_pop();
      do_reset();
      rx_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         expq.push_back(8'h10 + 8'(k));
         send_frame(8'h10 + 8'(k), 1'b1);
         tick(2);
      end
      n_tests++;
      if (fill !== FW'(4) || overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL full_pre: got fill=%0d ovr=%b, required 4 0", fill, overrun);
      end
      expq.push_back(8'h14);
      fork
         send_frame(8'h14, 1'b1);
         begin
            tick(78);
            rx_ready = 1'b1;
            tick(1);
            rx_ready = 1'b0;
         end
      join
      tick(2);
      n_tests++;
      if (fill !== FW'(4) || overrun !== 1'b0 || rx_data !== 8'h11) begin
         n_fail++;
         $display("FAIL full_push_pop: got fill=%0d ovr=%b head=%h, required 4 0 11", fill, overrun, rx_data);
      end
      rx_ready = 1'b1;
      tick(8);
      n_tests++;
      if (fill !== FW'(0) || expq.size() != 0) begin
         n_fail++;
         $display("FAIL full_drain: got fill=%0d pending=%0d, required 0 0", fill, expq.size());
      end
   endtask

   initial begin
      rst = 1'b1;
      rxd = 1'b1;
      rx_ready = 1'b0;
      test_reset();
      test_single();
      test_glitch();
      test_frame_err();
      test_back_to_back();
      test_overrun();
      test_reset_mid_frame();
      test_full_pop();
      tick(4);
      n_tests++;
      if (expq.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drained: got %0d pending, required 0", expq.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
